// File: rtl/round_timer_pkg.sv
// Shared definitions for the round timer and its consumers (score/display):
// state encoding plus the default round length and step size.
package round_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int DEFAULT_ROUND_SEC = 180;
  localparam int DEFAULT_STEP_SEC  = 30;

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronises an asynchronous level into clk and flags every toggle (both edges).
// edge_out is high for one cycle, SYNC_STAGES edges after the level is first sampled.
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/round_timer.sv
// Game round countdown driven by toggles of the 30 s divider output; saturating decrement.
// Optional low-time warning output enabled by defining ROUND_TIMER_WARN_EN.
module round_timer
  import round_timer_pkg::*;
#(
  parameter int ROUND_SEC   = DEFAULT_ROUND_SEC,
  parameter int STEP_SEC    = DEFAULT_STEP_SEC,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
`ifdef ROUND_TIMER_WARN_EN
  ,
  parameter int WARN_SEC    = 30
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start,
  input  logic             pause,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       state,
  output logic             running,
  output logic             expired,
  output logic             step_pulse,
  output logic             expire_pulse,
  output logic             warn
);

  localparam logic [CNT_W-1:0] ROUND_C = CNT_W'(ROUND_SEC);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP_SEC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             step_q, step_d;
  logic             expire_q, expire_d;
  logic             tick_edge;

  tick_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (tick_in),
    .edge_out (tick_edge)
  );

  // start outranks everything; in RUN, pause outranks a same-cycle tick edge.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    step_d      = 1'b0;
    expire_d    = 1'b0;
    if (start) begin
      state_d     = ST_RUN;
      remaining_d = ROUND_C;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick_edge) begin
            step_d = 1'b1;
            if (remaining_q > STEP_C) begin
              remaining_d = remaining_q - STEP_C;
            end else begin
              remaining_d = '0;
              expire_d    = 1'b1;
              state_d     = ST_EXPIRED;
            end
          end
        end
        ST_PAUSED: begin
          if (pause) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      step_q      <= 1'b0;
      expire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      step_q      <= step_d;
      expire_q    <= expire_d;
    end
  end

  assign remaining    = remaining_q;
  assign state        = state_q;
  assign running      = (state_q == ST_RUN);
  assign expired      = (state_q == ST_EXPIRED);
  assign step_pulse   = step_q;
  assign expire_pulse = expire_q;

`ifdef ROUND_TIMER_WARN_EN
  localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_SEC);

  logic warn_q, warn_d;

  // Evaluated on next-state values so warn moves on the same edge as remaining.
  assign warn_d = ((state_d == ST_RUN) || (state_d == ST_PAUSED)) &&
                  (remaining_d != '0) && (remaining_d <= WARN_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) warn_q <= 1'b0;
    else       warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer.sv
// Bench for round_timer: two instances (default and ROUND_SEC=100) on shared stimulus,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_round_timer;

  localparam int SYNC = 2;
`ifdef ROUND_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif
  localparam int ROUNDS [2] = '{180, 100};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick_in = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;

  logic [7:0] rem_o   [2];
  logic [1:0] st_o    [2];
  logic       run_o   [2];
  logic       expd_o  [2];
  logic       step_o  [2];
  logic       xpl_o   [2];
  logic       warn_o  [2];

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  round_timer u_dut0 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .pause(pause),
    .remaining(rem_o[0]), .state(st_o[0]), .running(run_o[0]), .expired(expd_o[0]),
    .step_pulse(step_o[0]), .expire_pulse(xpl_o[0]), .warn(warn_o[0])
  );

  round_timer #(.ROUND_SEC(100)) u_dut1 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start(start), .pause(pause),
    .remaining(rem_o[1]), .state(st_o[1]), .running(run_o[1]), .expired(expd_o[1]),
    .step_pulse(step_o[1]), .expire_pulse(xpl_o[1]), .warn(warn_o[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a toggle takes effect SYNC+1 edges after it is first sampled.
  int m_rem [2];
  int m_st  [2];
  bit m_step [2];
  bit m_xpl  [2];
  bit m_warn [2];
  bit lvl [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl = {};
      for (int k = 0; k < SYNC + 2; k++) lvl.push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
        m_rem[i] = 0; m_st[i] = 0; m_step[i] = 0; m_xpl[i] = 0; m_warn[i] = 0;
      end
    end else begin
      bit ev;
      lvl.push_front(tick_in);
      void'(lvl.pop_back());
      ev = (lvl[SYNC] != lvl[SYNC+1]);
      for (int i = 0; i < 2; i++) begin
        m_step[i] = 0;
        m_xpl[i]  = 0;
        if (start) begin
          m_rem[i] = ROUNDS[i];
          m_st[i]  = 1;
        end else if (m_st[i] == 1 && pause) begin
          m_st[i] = 2;
        end else if (m_st[i] == 1 && ev) begin
          m_step[i] = 1;
          if (m_rem[i] > 30) m_rem[i] = m_rem[i] - 30;
          else begin
            m_rem[i] = 0; m_xpl[i] = 1; m_st[i] = 3;
          end
        end else if (m_st[i] == 2 && pause) begin
          m_st[i] = 1;
        end
        m_warn[i] = WARN_ON && (m_st[i] == 1 || m_st[i] == 2) && m_rem[i] > 0 && m_rem[i] <= 30;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rem[%0d]", i),    int'(rem_o[i]),  m_rem[i]);
        chk($sformatf("state[%0d]", i),  int'(st_o[i]),   m_st[i]);
        chk($sformatf("running[%0d]", i), int'(run_o[i]), int'(m_st[i] == 1));
        chk($sformatf("expired[%0d]", i), int'(expd_o[i]), int'(m_st[i] == 3));
        chk($sformatf("step[%0d]", i),   int'(step_o[i]), int'(m_step[i]));
        chk($sformatf("xpulse[%0d]", i), int'(xpl_o[i]),  int'(m_xpl[i]));
        chk($sformatf("warn[%0d]", i),   int'(warn_o[i]), int'(m_warn[i]));
      end
    end
  end

  task automatic drv(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; drv(1); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; drv(1); pause = 1'b0;
  endtask

  // Toggle, then return just after the 3rd edge following the first sampling edge.
  task automatic tog();
    tick_in = ~tick_in;
    drv(3);
  endtask

  localparam int T1_R0 [6] = '{150, 120, 90, 60, 30, 0};
  localparam int T1_R1 [6] = '{70, 40, 10, 0, 0, 0};
  localparam int T1_S1 [6] = '{1, 1, 1, 1, 0, 0};
  localparam int T1_X1 [6] = '{0, 0, 0, 1, 0, 0};

  initial begin
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    drv(3);
    chk("rst_rem", int'(rem_o[0]), 0);
    chk("rst_state", int'(st_o[0]), 0);
    chk("rst_step", int'(step_o[0]), 0);
    chk("rst_warn", int'(warn_o[0]), 0);
    reset = 1'b0;
    drv(2);

    // Full round at default and ROUND_SEC=100 (the latter runs past expiry).
    pulse_start();
    chk("t1_start_rem", int'(rem_o[0]), 180);
    chk("t1_start_rem100", int'(rem_o[1]), 100);
    chk("t1_running", int'(run_o[0]), 1);
    for (int k = 0; k < 6; k++) begin
      int r0, r1;
      r0 = T1_R0[k];
      r1 = T1_R1[k];
      tick_in = ~tick_in;
      drv(2);
      chk("t1_pre_rem", int'(rem_o[0]), (k == 0) ? 180 : T1_R0[k-1]);
      chk("t1_pre_step", int'(step_o[0]), 0);
      drv(1);
      chk("t1_rem", int'(rem_o[0]), r0);
      chk("t1_step", int'(step_o[0]), 1);
      chk("t1_xpulse", int'(xpl_o[0]), (k == 5) ? 1 : 0);
      chk("t2_rem", int'(rem_o[1]), r1);
      chk("t2_step", int'(step_o[1]), T1_S1[k]);
      chk("t2_xpulse", int'(xpl_o[1]), T1_X1[k]);
      drv(1);
      chk("t1_step_one_cycle", int'(step_o[0]), 0);
      drv(8);
    end
    chk("t1_state", int'(st_o[0]), 3);
    chk("t1_expired", int'(expd_o[0]), 1);
    chk("t2_expired", int'(expd_o[1]), 1);
    chk("t1_warn_exp", int'(warn_o[0]), 0);

    // Tick edge coincident with start, then coincident with pause.
    tick_in = ~tick_in;
    drv(2);
    start = 1'b1; drv(1); start = 1'b0;
    chk("t4_start_rem", int'(rem_o[0]), 180);
    chk("t4_start_step", int'(step_o[0]), 0);
    drv(5);
    tick_in = ~tick_in;
    drv(2);
    pause = 1'b1; drv(1); pause = 1'b0;
    chk("t4_pause_state", int'(st_o[0]), 2);
    chk("t4_pause_rem", int'(rem_o[0]), 180);
    chk("t4_pause_step", int'(step_o[0]), 0);
    drv(5);
    pulse_pause();
    chk("t4_resume", int'(st_o[0]), 1);
    drv(5);

    // Pause at 120: toggles in PAUSED are discarded.
    tog(); drv(8);
    tog(); drv(8);
    chk("t3_rem120", int'(rem_o[0]), 120);
    pulse_pause();
    chk("t3_paused", int'(st_o[0]), 2);
    repeat (3) begin
      tog(); drv(8);
    end
    chk("t3_hold_rem", int'(rem_o[0]), 120);
    pulse_pause();
    chk("t3_run_again", int'(st_o[0]), 1);
    tog();
    chk("t3_rem90", int'(rem_o[0]), 90);
    drv(8);

    // Asynchronous reset mid-cycle with an edge in flight and tick_in high.
    if (tick_in == 1'b0) tick_in = 1'b1;
    drv(1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_rem_clr", int'(rem_o[0]), 0);
    chk("t5_state_clr", int'(st_o[0]), 0);
    chk("t5_running_clr", int'(run_o[0]), 0);
    drv(2);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drv(1);
      chk("t5_no_step", int'(step_o[0]), 0);
    end

    // Warning threshold.
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      tog(); drv(8);
    end
    chk("t6_rem60", int'(rem_o[0]), 60);
    chk("t6_warn60", int'(warn_o[0]), 0);
    tog();
    chk("t6_rem30", int'(rem_o[0]), 30);
    chk("t6_warn30", int'(warn_o[0]), WARN_ON ? 1 : 0);
    pulse_pause();
    drv(3);
    chk("t6_warn_paused", int'(warn_o[0]), WARN_ON ? 1 : 0);
    pulse_pause();
    tog();
    chk("t6_rem0", int'(rem_o[0]), 0);
    chk("t6_warn_expired", int'(warn_o[0]), 0);
    drv(4);

    // Randomised phase against the model.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) tick_in = ~tick_in;
      drv(1);
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0;
    drv(2);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
